// File: rtl/linear_layer_start_fifo_srl_reader.sv
// Purpose: read-side controller + storage for the SRL start/handshake FIFO, capacity DEPTH+1.
// Latency: push into empty FIFO -> if_empty_n high after the following edge (SRL, then out reg).
// Backpressure: if_full_n from registered count only; one push + one take per cycle sustained.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   if_write_ce/if_write/if_din   write side; push only when if_full_n = 1
//   if_full_n                 1 = SRL has room for a push this cycle
//   if_read_ce/if_read        consumer takes if_dout this cycle when if_empty_n = 1
//   if_dout/if_empty_n        registered head-of-queue data and its valid flag
module linear_layer_start_fifo_srl_reader #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic [ADDR_WIDTH:0]   cnt;
    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_data;

    logic                  push;
    logic                  take;
    logic                  load;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] head;

    assign push = if_write & if_write_ce & if_full_n;
    assign take = if_read & if_read_ce & out_vld;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign load = (cnt != '0) & (~out_vld | take);

    // Oldest entry sits at index cnt-1 since the newest is always shifted in at 0.
    // rd_idx is meaningless when cnt = 0, but load is low then.
    assign rd_idx = ADDR_WIDTH'(cnt - (ADDR_WIDTH + 1)'(1));

    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == ADDR_WIDTH'(i)) begin
                head = srl[i];
            end
        end
    end

    // Shift register storage carries no reset: contents are qualified by cnt.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            srl[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                srl[i] <= srl[i-1];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt <= '0;
        end else if (push & ~load) begin
            cnt <= cnt + (ADDR_WIDTH + 1)'(1);
        end else if (~push & load) begin
            cnt <= cnt - (ADDR_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_data <= head;
        end else if (take) begin
            out_vld  <= 1'b0;
        end
    end

    // Full decoded from registered count: a same-cycle take does not reopen the SRL.
    assign if_full_n  = (cnt != DEPTH_C);
    assign if_empty_n = out_vld;
    assign if_dout    = out_data;

    a_cnt_bound: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        cnt <= DEPTH_C);

    a_no_stall: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        (cnt != '0 && !out_vld) |=> out_vld);

endmodule
